// File: rtl/io_oserdes.sv
// Parallel-to-serial output serializer (LSB first) with a one-word holding register for gapless streaming.
// Optional even-parity bit after each word when IOSER_PARITY_EN is defined.
module io_oserdes #(
  parameter int WIDTH = 8
) (
  input  logic             IOCLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DIN,
  input  logic             DVALID,
  output logic             DREADY,
  output logic             OUT,
  output logic             TS,
  output logic             BUSY
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
`ifdef IOSER_PARITY_EN
  localparam logic [1:0] ST_PAR   = 2'd2;
`endif

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             ts_q, ts_d;
`ifdef IOSER_PARITY_EN
  logic             par_q, par_d;
`endif

  logic             xfer;
  logic             frame_end;
  logic             load_en;
  logic [WIDTH-1:0] load_w;

  assign xfer = DVALID & ~hold_full_q;

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    cnt_d       = cnt_q;
`ifdef IOSER_PARITY_EN
    par_d       = par_q;
`endif
    frame_end   = 1'b0;
    load_en     = 1'b0;
    load_w      = DIN;

    case (state_q)
      ST_SHIFT: begin
        shreg_d = shreg_q >> 1;
        cnt_d   = cnt_q + 1'b1;
`ifdef IOSER_PARITY_EN
        if (cnt_q == LAST) begin
          state_d = ST_PAR;
          cnt_d   = '0;
        end
        if (xfer) begin
          hold_d      = DIN;
          hold_full_d = 1'b1;
        end
`else
        frame_end = (cnt_q == LAST);
        if (xfer && !frame_end) begin
          hold_d      = DIN;
          hold_full_d = 1'b1;
        end
`endif
      end
`ifdef IOSER_PARITY_EN
      ST_PAR: frame_end = 1'b1;
`endif
      default: begin
        // Idle transfers bypass the holding register entirely.
        if (xfer) load_en = 1'b1;
      end
    endcase

    if (frame_end) begin
      if (hold_full_q) begin
        load_en     = 1'b1;
        load_w      = hold_q;
        hold_full_d = 1'b0;
      end else if (xfer) begin
        load_en = 1'b1;
      end else begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    end

    if (load_en) begin
      shreg_d = load_w;
      cnt_d   = '0;
      state_d = ST_SHIFT;
`ifdef IOSER_PARITY_EN
      par_d   = ^load_w;
`endif
    end

    // Pin outputs are registered from the next-state view so they change cleanly on the edge.
    out_d = 1'b0;
    if (state_d == ST_SHIFT) out_d = shreg_d[0];
`ifdef IOSER_PARITY_EN
    if (state_d == ST_PAR) out_d = par_q;
`endif
    ts_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge IOCLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      cnt_q       <= '0;
      out_q       <= 1'b0;
      ts_q        <= 1'b0;
`ifdef IOSER_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      ts_q        <= ts_d;
`ifdef IOSER_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

  assign DREADY = ~hold_full_q & ~RST;
  assign OUT    = out_q;
  assign TS     = ts_q;
  assign BUSY   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_io_oserdes.sv
// Self-checking bench for io_oserdes: directed vector table, hand sequences and randomized traffic
// compared against a bit-stream reference model.
module tb_io_oserdes;
  localparam int W = 8;

  logic         IOCLK = 1'b0;
  logic         RST;
  logic         DVALID;
  logic [W-1:0] DIN;
  logic         DREADY, OUT, TS, BUSY;

  io_oserdes #(.WIDTH(W)) dut (
    .IOCLK (IOCLK),
    .RST   (RST),
    .DIN   (DIN),
    .DVALID(DVALID),
    .DREADY(DREADY),
    .OUT   (OUT),
    .TS    (TS),
    .BUSY  (BUSY)
  );

  always #5 IOCLK = ~IOCLK;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of bits still to appear on the pin (head = current bit) plus one held word.
  bit         frame[$];
  bit         held_v;
  logic [W-1:0] held_w;
  bit         last_xfer;

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         o;
    logic         ts;
    logic         busy;
    logic         rdy;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(input logic v, input logic [W-1:0] d, input logic o,
                              input logic ts, input logic busy, input logic rdy);
    vec_t r;
    r.v = v; r.d = d; r.o = o; r.ts = ts; r.busy = busy; r.rdy = rdy;
    return r;
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    frame.delete();
    held_v = 1'b0;
    held_w = '0;
  endtask

  task automatic push_word(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) frame.push_back(w[i]);
`ifdef IOSER_PARITY_EN
    frame.push_back(^w);
`endif
  endtask

  task automatic model_edge(input logic v, input logic [W-1:0] d);
    bit b;
    last_xfer = v && !held_v;
    if (frame.size() > 0) b = frame.pop_front();
    if (frame.size() == 0) begin
      if (held_v) begin
        push_word(held_w);
        held_v = 1'b0;
      end else if (last_xfer) begin
        push_word(d);
      end
    end else if (last_xfer) begin
      held_v = 1'b1;
      held_w = d;
    end
  endtask

  task automatic check_model(input string name);
    chk({name, " OUT"},    OUT,    (frame.size() > 0) ? frame[0] : 1'b0);
    chk({name, " TS"},     TS,     frame.size() > 0);
    chk({name, " BUSY"},   BUSY,   frame.size() > 0);
    chk({name, " DREADY"}, DREADY, !held_v);
  endtask

  task automatic cycle(input string name, input logic v, input logic [W-1:0] d);
    DVALID = v;
    DIN    = d;
    @(posedge IOCLK);
    model_edge(v, d);
    #1;
    check_model(name);
  endtask

  initial begin
    int           idx;
    int           ts_run;
    bit           saw_stall;
    logic [W-1:0] words [3];
    logic [W-1:0] exp81;

    tbl[0]  = mk(1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b1);
    tbl[1]  = mk(1'b1, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0);
    tbl[2]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
    tbl[3]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    tbl[4]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    tbl[5]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
    tbl[6]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    tbl[7]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
    tbl[8]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
    tbl[9]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
    tbl[10] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
    tbl[11] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
    tbl[12] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
    tbl[13] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
    tbl[14] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
    tbl[15] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
    tbl[16] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

    RST    = 1'b1;
    DVALID = 1'b1;
    DIN    = 8'hFF;
    model_reset();
    repeat (2) @(posedge IOCLK);
    #1;
    chk("reset OUT", OUT, 1'b0);
    chk("reset TS", TS, 1'b0);
    chk("reset BUSY", BUSY, 1'b0);
    chk("reset DREADY", DREADY, 1'b0);
    RST    = 1'b0;
    DVALID = 1'b0;

`ifndef IOSER_PARITY_EN
    // A5 then 3C back to back: 16 gapless bits, then idle.
    for (int i = 0; i < 17; i++) begin
      DVALID = tbl[i].v;
      DIN    = tbl[i].d;
      @(posedge IOCLK);
      model_edge(tbl[i].v, tbl[i].d);
      #1;
      chk($sformatf("tbl[%0d] OUT", i), OUT, tbl[i].o);
      chk($sformatf("tbl[%0d] TS", i), TS, tbl[i].ts);
      chk($sformatf("tbl[%0d] BUSY", i), BUSY, tbl[i].busy);
      chk($sformatf("tbl[%0d] DREADY", i), DREADY, tbl[i].rdy);
    end
`else
    cycle("par A5 load", 1'b1, 8'hA5);
    for (int i = 1; i < 9; i++) cycle("par A5", 1'b0, 8'h00);
    chk("par A5 parity bit", OUT, 1'b0);
    chk("par A5 TS on parity", TS, 1'b1);
    cycle("par A5 end", 1'b0, 8'h00);
    chk("par A5 TS after", TS, 1'b0);
    cycle("par 07 load", 1'b1, 8'h07);
    for (int i = 1; i < 9; i++) cycle("par 07", 1'b0, 8'h00);
    chk("par 07 parity bit", OUT, 1'b1);
    cycle("par 07 end", 1'b0, 8'h00);
`endif

    // DVALID held high over three words: back-pressure, order, no drops.
    words[0] = 8'h01; words[1] = 8'h02; words[2] = 8'h03;
    idx = 0; ts_run = 0; saw_stall = 1'b0;
    for (int c = 0; c < 45; c++) begin
      if (idx < 3 && !held_v) saw_stall = saw_stall;
      if (idx < 3 && held_v) saw_stall = 1'b1;
      cycle("stream3", idx < 3, (idx < 3) ? words[idx] : 8'h00);
      if (last_xfer) idx++;
      if (TS) ts_run++;
    end
    chk_int("stream3 words accepted", idx, 3);
`ifndef IOSER_PARITY_EN
    chk_int("stream3 TS cycles", ts_run, 24);
`else
    chk_int("stream3 TS cycles", ts_run, 27);
`endif
    chk("stream3 saw DREADY low", saw_stall, 1'b1);

    // Reset during bit 4 of FF aborts at once; next word starts clean.
    cycle("abort load", 1'b1, 8'hFF);
    for (int i = 0; i < 4; i++) cycle("abort run", 1'b0, 8'h00);
    #2;
    RST = 1'b1;
    #1;
    chk("abort TS", TS, 1'b0);
    chk("abort OUT", OUT, 1'b0);
    chk("abort BUSY", BUSY, 1'b0);
    chk("abort DREADY", DREADY, 1'b0);
    model_reset();
    #1;
    RST = 1'b0;
    exp81 = 8'h81;
    cycle("after abort load", 1'b1, 8'h81);
    chk("after abort bit0", OUT, exp81[0]);
    for (int i = 1; i < 8; i++) begin
      cycle("after abort", 1'b0, 8'h00);
      chk($sformatf("after abort bit%0d", i), OUT, exp81[i]);
    end
    repeat (3) cycle("after abort tail", 1'b0, 8'h00);

    // Randomized traffic with varying offered load.
    for (int c = 0; c < 1500; c++) begin
      logic v;
      case ((c / 250) % 3)
        0:       v = ($urandom_range(0, 3) != 0);
        1:       v = ($urandom_range(0, 9) == 0);
        default: v = 1'b1;
      endcase
      cycle("random", v, W'($urandom));
    end
    repeat (12) cycle("drain", 1'b0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
